plot_scheduler: RTL and testbench
=================================

// Module: plot_scheduler
// PURPOSE
//  Sole owner of the vga_adapter plot port (x, y, colour, plot). Arbitrates cell-draw requests from the
//  load path and the simulation redraw path, expands each grid cell into a CELL_PX x CELL_PX pixel block,
//  and runs a full-screen clear sweep on demand. One pixel is written per clock; requesters stall via ready.
// PARAMETERS
//  GRID_W   4    grid columns; cell x >= GRID_W is out of range
//  GRID_H   4    grid rows; cell y >= GRID_H is out of range
//  CELL_PX  4    pixel edge length of one cell block (>= 1)
//  SCR_W    160  screen width in pixels (clear sweep extent)
//  SCR_H    120  screen height in pixels (clear sweep extent)
// PORTS
//  clock       in   1  system clock (CLOCK_50)
//  reset_n     in   1  synchronous, active-low reset
//  clr_req     in   1  one-cycle pulse: clear whole screen to colour 3'b000
//  clr_busy    out  1  high while a clear is pending or sweeping
//  ld_valid    in   1  load-path cell draw request
//  ld_ready    out  1  load-path request accepted this cycle when ld_valid & ld_ready
//  ld_x, ld_y  in   8  load-path cell coordinates
//  ld_colour   in   3  load-path cell colour
//  sim_valid   in   1  simulation-path cell draw request
//  sim_ready   out  1  simulation-path accept
//  sim_x,sim_y in   8  simulation-path cell coordinates
//  sim_colour  in   3  simulation-path cell colour
//  vga_x       out  8  pixel x to vga_adapter
//  vga_y       out  8  pixel y to vga_adapter
//  vga_colour  out  3  pixel colour to vga_adapter
//  vga_plot    out  1  pixel write strobe, one pixel per high cycle
//  idle        out  1  state == IDLE and no clear pending
// BEHAVIOUR
//  - Reset: state IDLE; vga_x/vga_y/vga_colour = 0, vga_plot = 0, clr_pend = 0, last_grant = SIM.
//    Reset mid-BLOCK or mid-CLEAR aborts immediately; vga_plot is 0 the cycle after reset is sampled.
//  - States: IDLE, BLOCK, CLEAR. Pixel outputs are registered.
//  - clr_req sets clr_pend in any state except CLEAR (ignored in CLEAR). clr_busy = clr_pend | (state==CLEAR).
//  - IDLE: if clr_pend or clr_req -> CLEAR (clr_pend cleared, both readys low). Otherwise grant:
//    only one valid -> that one; both valid -> requester != last_grant (round robin).
//    ready is combinational: high only in IDLE, no clear pending/requested, for the granted requester.
//    Never both readys high in one cycle. On accept: latch x, y, colour; last_grant <= accepted requester.
//  - Accept with cell x >= GRID_W or y >= GRID_H: request consumed, no pixel plotted, stay IDLE.
//  - BLOCK: latched cell (cx, cy); pixel offsets (px, py) raster order, px fastest, 0..CELL_PX-1.
//    vga_x = cx*CELL_PX + px, vga_y = cy*CELL_PX + py, vga_colour = latched colour, vga_plot = 1.
//    Accept at cycle N -> plots in cycles N+1 .. N+CELL_PX^2; state returns to IDLE so the next accept
//    can occur at N+CELL_PX^2 (earliest next plot N+CELL_PX^2+1). No other request accepted meanwhile.
//  - CLEAR: sweeps x 0..SCR_W-1 (fastest), y 0..SCR_H-1, colour 3'b000, vga_plot = 1 each cycle;
//    exactly SCR_W*SCR_H plots; after (SCR_W-1, SCR_H-1) -> IDLE.
//  - clr_req arriving during BLOCK: block completes fully, then CLEAR begins; pending cell requests wait.
//  - Arithmetic: pixel coords computed at 8 bits; caller guarantees GRID_W*CELL_PX <= SCR_W, same for H.
//  - vga_plot = 0 and outputs hold last values in IDLE.
// TESTING
//  1. ld (x=1,y=2,colour=111), CELL_PX=4 -> 16 plots, x 4..7 fastest, y 8..11, colour 111, first plot
//     one cycle after handshake; ld_ready low throughout; idle=1 afterwards.
//  2. ld_valid and sim_valid both held high from reset -> accept order ld, sim, ld, sim; each 16 plots.
//  3. clr_req during cycle 5 of a block -> block finishes all 16 plots, clr_busy high, then 19200 plots
//     colour 000 ending at (159,119); readys low until done.
//  4. ld (x=4,y=0) -> accepted, zero vga_plot cycles, ld_ready high again next cycle.
//  5. reset_n low mid-CLEAR -> next cycle vga_plot=0, vga_x=vga_y=0, clr_busy=0, idle=1.
//  6. clr_req pulsed again during CLEAR -> ignored; exactly 19200 plots total, then IDLE.

Source files
------------

// File: rtl/plot_scheduler.sv
// plot_scheduler
//   Sole owner of the vga_adapter plot port. It arbitrates cell-draw requests
//   from the load path and the simulation redraw path. Each accepted grid cell
//   is expanded into a CELL_PX x CELL_PX block of pixels. On request it also
//   runs a full-screen clear sweep to colour 0. One pixel is written per clock,
//   and requesters are stalled through their ready signals.
//
// Ports
//   clock, reset_n            system clock; synchronous active-low reset
//   clr_req                   one-cycle pulse requesting a full-screen clear
//   clr_busy                  a clear is pending or sweeping
//   ld_valid/ld_ready         load-path handshake (ready is combinational)
//   ld_x, ld_y, ld_colour     load-path cell coordinates and colour
//   sim_valid/sim_ready       simulation-path handshake (ready is combinational)
//   sim_x, sim_y, sim_colour  simulation-path cell coordinates and colour
//   vga_x, vga_y, vga_colour  registered pixel position and colour
//   vga_plot                  registered pixel write strobe
//   idle                      no block or clear in progress and no clear pending
//
// The clear sweep assumes SCR_W >= 2.
module plot_scheduler #(
    parameter int GRID_W  = 4,
    parameter int GRID_H  = 4,
    parameter int CELL_PX = 4,
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr_req,
    output logic       clr_busy,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [7:0] ld_x,
    input  logic [7:0] ld_y,
    input  logic [2:0] ld_colour,
    input  logic       sim_valid,
    output logic       sim_ready,
    input  logic [7:0] sim_x,
    input  logic [7:0] sim_y,
    input  logic [2:0] sim_colour,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       idle
);

    typedef enum logic [1:0] {IDLE, BLOCK, CLEAR} state_t;

    localparam logic [7:0] GRID_W8   = 8'(GRID_W);
    localparam logic [7:0] GRID_H8   = 8'(GRID_H);
    localparam logic [7:0] CELL8     = 8'(CELL_PX);
    localparam logic [7:0] CELL_LAST = 8'(CELL_PX - 1);
    localparam logic [7:0] X_LAST    = 8'(SCR_W - 1);
    localparam logic [7:0] Y_LAST    = 8'(SCR_H - 1);

    state_t     state_q;
    logic       clr_pend_q;
    logic       last_sim_q;     // 1: the last accepted request came from the sim path
    logic [7:0] base_x_q;       // pixel origin of the cell being drawn
    logic [7:0] base_y_q;
    logic [2:0] colour_q;
    logic [7:0] px_q;           // offset of the next pixel to emit (block or clear)
    logic [7:0] py_q;
    logic [7:0] vga_x_q;
    logic [7:0] vga_y_q;
    logic [2:0] vga_colour_q;
    logic       vga_plot_q;

    logic       can_accept;
    logic       grant_ld;
    logic       grant_sim;
    logic       accept;
    logic       in_range;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic [2:0] sel_colour;
    logic [7:0] cell_base_x;
    logic [7:0] cell_base_y;

    // Round-robin grant: a lone requester always wins; when both are valid,
    // the one that was not served last wins. A clear that is pending or being
    // requested this cycle takes priority over both requesters.
    always_comb begin
        can_accept  = (state_q == IDLE) && !clr_pend_q && !clr_req;
        grant_ld    = ld_valid && (!sim_valid || last_sim_q);
        grant_sim   = sim_valid && (!ld_valid || !last_sim_q);
        ld_ready    = can_accept && grant_ld;
        sim_ready   = can_accept && grant_sim;
        accept      = ld_ready || sim_ready;
        sel_x       = grant_sim ? sim_x : ld_x;
        sel_y       = grant_sim ? sim_y : ld_y;
        sel_colour  = grant_sim ? sim_colour : ld_colour;
        in_range    = (sel_x < GRID_W8) && (sel_y < GRID_H8);
        cell_base_x = sel_x * CELL8;
        cell_base_y = sel_y * CELL8;
    end

    // The first pixel of a block or sweep is registered on the entry edge.
    // The state returns to IDLE on the edge that registers the last pixel, so
    // a new request can be accepted while the last pixel is on the port.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_pend_q   <= 1'b0;
            last_sim_q   <= 1'b1;
            base_x_q     <= 8'd0;
            base_y_q     <= 8'd0;
            colour_q     <= 3'd0;
            px_q         <= 8'd0;
            py_q         <= 8'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 8'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
        end else begin
            vga_plot_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_pend_q || clr_req) begin
                        clr_pend_q   <= 1'b0;
                        vga_x_q      <= 8'd0;
                        vga_y_q      <= 8'd0;
                        vga_colour_q <= 3'd0;
                        vga_plot_q   <= 1'b1;
                        px_q         <= 8'd1;
                        py_q         <= 8'd0;
                        state_q      <= CLEAR;
                    end else if (accept) begin
                        last_sim_q <= sim_ready;
                        // An out-of-range cell is consumed without drawing anything.
                        if (in_range) begin
                            base_x_q     <= cell_base_x;
                            base_y_q     <= cell_base_y;
                            colour_q     <= sel_colour;
                            vga_x_q      <= cell_base_x;
                            vga_y_q      <= cell_base_y;
                            vga_colour_q <= sel_colour;
                            vga_plot_q   <= 1'b1;
                            px_q         <= 8'd1;
                            py_q         <= 8'd0;
                            // A one-pixel cell is complete on the entry edge.
                            if (CELL_LAST != 8'd0) begin
                                state_q <= BLOCK;
                            end
                        end
                    end
                end
                BLOCK: begin
                    if (clr_req) begin
                        clr_pend_q <= 1'b1;
                    end
                    vga_x_q      <= base_x_q + px_q;
                    vga_y_q      <= base_y_q + py_q;
                    vga_colour_q <= colour_q;
                    vga_plot_q   <= 1'b1;
                    if (px_q == CELL_LAST) begin
                        px_q <= 8'd0;
                        if (py_q == CELL_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            py_q <= py_q + 8'd1;
                        end
                    end else begin
                        px_q <= px_q + 8'd1;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately ignored while sweeping.
                    vga_x_q      <= px_q;
                    vga_y_q      <= py_q;
                    vga_colour_q <= 3'd0;
                    vga_plot_q   <= 1'b1;
                    if (px_q == X_LAST) begin
                        px_q <= 8'd0;
                        if (py_q == Y_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            py_q <= py_q + 8'd1;
                        end
                    end else begin
                        px_q <= px_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign clr_busy   = clr_pend_q || (state_q == CLEAR);
    assign idle       = (state_q == IDLE) && !clr_pend_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler
//   Drives plot_scheduler with directed scenarios and a randomized phase.
//   A transaction-level reference model predicts the pixel stream, the ready
//   signals and the status flags for every cycle.
module tb_plot_scheduler;

    localparam int GRID_W  = 4;
    localparam int GRID_H  = 4;
    localparam int CELL_PX = 4;
    localparam int SCR_W   = 160;
    localparam int SCR_H   = 120;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clr_req;
    logic       clr_busy;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_x;
    logic [7:0] ld_y;
    logic [2:0] ld_colour;
    logic       sim_valid;
    logic       sim_ready;
    logic [7:0] sim_x;
    logic [7:0] sim_y;
    logic [2:0] sim_colour;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       idle;

    plot_scheduler #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .CELL_PX(CELL_PX),
        .SCR_W  (SCR_W),
        .SCR_H  (SCR_H)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .ld_colour (ld_colour),
        .sim_valid (sim_valid),
        .sim_ready (sim_ready),
        .sim_x     (sim_x),
        .sim_y     (sim_y),
        .sim_colour(sim_colour),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .idle      (idle)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of pixels still to appear on the port, one per
    // cycle, plus the clear-pending flag and the round-robin memory.
    logic [18:0] expq[$];
    bit          m_pend;
    bit          m_last_sim;
    bit          m_clr;
    logic [7:0]  lx, ly;
    logic [2:0]  lc;

    // Observation counters.
    int          nplots;
    int          nclr0;
    logic [15:0] lastclr;
    int          acc_q[$];
    bit          hs_ld, hs_sim;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        m_pend     = 1'b0;
        m_last_sim = 1'b1;
        m_clr      = 1'b0;
        lx         = 8'd0;
        ly         = 8'd0;
        lc         = 3'd0;
    endtask

    // Runs at the falling edge: check this cycle, then advance the model over
    // the coming rising edge.
    task automatic model_step();
        bit e_plot, m_busy, e_busy, e_idle, can, g_ld, g_sim, e_ldr, e_simr;
        int cx, cy, cc;
        e_plot = 1'b0;
        if (expq.size() > 0) begin
            e_plot = 1'b1;
            {lx, ly, lc} = expq.pop_front();
        end
        m_busy = (expq.size() != 0);
        e_busy = m_pend || (m_busy && m_clr);
        e_idle = !m_busy && !m_pend;
        can    = !m_busy && !m_pend && !clr_req;
        g_ld   = ld_valid && (!sim_valid || m_last_sim);
        g_sim  = sim_valid && (!ld_valid || !m_last_sim);
        e_ldr  = can && g_ld;
        e_simr = can && g_sim;
        chk("cycle {rdy_ld,rdy_sim,plot,busy,idle,x,y,col}",
            {8'd0, ld_ready, sim_ready, vga_plot, clr_busy, idle, vga_x, vga_y, vga_colour},
            {8'd0, e_ldr, e_simr, e_plot, e_busy, e_idle, lx, ly, lc});

        hs_ld  = reset_n && ld_valid && ld_ready;
        hs_sim = reset_n && sim_valid && sim_ready;
        if (reset_n) begin
            if (vga_plot) nplots++;
            if (vga_plot && vga_colour == 3'd0) begin
                nclr0++;
                lastclr = {vga_x, vga_y};
            end
            if (hs_ld) acc_q.push_back(1);
            if (hs_sim) acc_q.push_back(2);
        end

        if (!reset_n) begin
            model_reset();
        end else if (!m_busy && (m_pend || clr_req)) begin
            m_pend = 1'b0;
            m_clr  = 1'b1;
            for (int y = 0; y < SCR_H; y++)
                for (int x = 0; x < SCR_W; x++)
                    expq.push_back({8'(x), 8'(y), 3'd0});
        end else if (e_ldr || e_simr) begin
            m_last_sim = e_simr;
            cx = e_simr ? int'(sim_x) : int'(ld_x);
            cy = e_simr ? int'(sim_y) : int'(ld_y);
            cc = e_simr ? int'(sim_colour) : int'(ld_colour);
            if (cx < GRID_W && cy < GRID_H) begin
                m_clr = 1'b0;
                for (int py = 0; py < CELL_PX; py++)
                    for (int px = 0; px < CELL_PX; px++)
                        expq.push_back({8'(cx * CELL_PX + px), 8'(cy * CELL_PX + py), 3'(cc)});
            end
        end else if (clr_req && !(m_busy && m_clr)) begin
            m_pend = 1'b1;
        end
    endtask

    // One clock: model at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input bit is_sim, input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] c, input int budget, input string tag);
        bit got;
        got = 1'b0;
        if (is_sim) begin
            sim_valid = 1'b1; sim_x = x; sim_y = y; sim_colour = c;
        end else begin
            ld_valid = 1'b1; ld_x = x; ld_y = y; ld_colour = c;
        end
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = is_sim ? hs_sim : hs_ld;
        end
        if (is_sim) sim_valid = 1'b0;
        else ld_valid = 1'b0;
        if (!got) chk({tag, "_handshake_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int base, base2, acc_base;
        bit done;
        reset_n = 1'b0; clr_req = 1'b0;
        ld_valid = 1'b0; ld_x = 8'd0; ld_y = 8'd0; ld_colour = 3'd0;
        sim_valid = 1'b0; sim_x = 8'd0; sim_y = 8'd0; sim_colour = 3'd0;
        nplots = 0; nclr0 = 0; lastclr = 16'd0;
        model_reset();

        @(posedge clock); #1;
        step();
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_xy", 32'({vga_x, vga_y, vga_colour}), 32'd0);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        reset_n = 1'b1;

        // Single load-path cell.
        req(1'b0, 8'd1, 8'd2, 3'b111, 50, "t1");
        base = nplots;
        repeat (20) step();
        chk("t1_plots", 32'(nplots - base), 32'd16);
        chk("t1_idle", 32'(idle), 32'd1);

        // Both requesters held valid from reset: round robin ld, sim, ld, sim.
        reset_n = 1'b0;
        ld_valid = 1'b1; ld_x = 8'd0; ld_y = 8'd0; ld_colour = 3'd1;
        sim_valid = 1'b1; sim_x = 8'd3; sim_y = 8'd3; sim_colour = 3'd2;
        step();
        reset_n = 1'b1;
        acc_base = acc_q.size();
        for (int i = 0; i < 200 && acc_q.size() < acc_base + 4; i++) step();
        ld_valid = 1'b0; sim_valid = 1'b0;
        if (acc_q.size() < acc_base + 4) begin
            chk("t2_accept_timeout", 32'(acc_q.size() - acc_base), 32'd4);
        end else begin
            chk("t2_order0", 32'(acc_q[acc_base]), 32'd1);
            chk("t2_order1", 32'(acc_q[acc_base + 1]), 32'd2);
            chk("t2_order2", 32'(acc_q[acc_base + 2]), 32'd1);
            chk("t2_order3", 32'(acc_q[acc_base + 3]), 32'd2);
        end
        repeat (20) step();

        // Clear requested mid-block, re-requested during the sweep, with a
        // simulation request waiting the whole time.
        base2 = nclr0;
        req(1'b0, 8'd2, 8'd1, 3'd5, 50, "t3_ld");
        repeat (4) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("t3_busy", 32'(clr_busy), 32'd1);
        sim_valid = 1'b1; sim_x = 8'd0; sim_y = 8'd1; sim_colour = 3'd3;
        repeat (500) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        req(1'b1, 8'd0, 8'd1, 3'd3, 25000, "t3_sim");
        repeat (20) step();
        chk("t3_clear_plots", 32'(nclr0 - base2), 32'(SCR_W * SCR_H));
        chk("t3_last_clear_px", 32'(lastclr), 32'({8'd159, 8'd119}));
        chk("t3_idle", 32'(idle), 32'd1);

        // Out-of-range cell: consumed, nothing drawn, ready again next cycle.
        base = nplots;
        ld_valid = 1'b1; ld_x = 8'd4; ld_y = 8'd0; ld_colour = 3'd6;
        step();
        chk("t4_accept", 32'(hs_ld), 32'd1);
        ld_y = 8'd5;
        step();
        chk("t4_ready_again", 32'(hs_ld), 32'd1);
        ld_valid = 1'b0;
        repeat (5) step();
        chk("t4_no_plots", 32'(nplots - base), 32'd0);

        // Reset in the middle of a clear sweep.
        req(1'b1, 8'd1, 8'd1, 3'd2, 50, "t5_sim");
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (200) step();
        chk("t5_sweeping", 32'(clr_busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("t5_plot", 32'(vga_plot), 32'd0);
        chk("t5_xy", 32'({vga_x, vga_y}), 32'd0);
        chk("t5_busy", 32'(clr_busy), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        reset_n = 1'b1;

        // Randomized traffic with one clear pulse in the middle.
        for (int i = 0; i < 2500; i++) begin
            ld_valid   = ($urandom_range(0, 3) != 0);
            ld_x       = 8'($urandom_range(0, 5));
            ld_y       = 8'($urandom_range(0, 5));
            ld_colour  = 3'($urandom_range(0, 7));
            sim_valid  = ($urandom_range(0, 3) != 0);
            sim_x      = 8'($urandom_range(0, 5));
            sim_y      = 8'($urandom_range(0, 5));
            sim_colour = 3'($urandom_range(0, 7));
            clr_req    = (i == 1000);
            step();
        end
        clr_req = 1'b0; ld_valid = 1'b0; sim_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 25000 && !done; i++) begin
            step();
            done = (expq.size() == 0) && !m_pend;
        end
        chk("drain_idle", 32'(idle), 32'd1);
        chk("drain_plot", 32'(vga_plot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
